// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous double-buffered load.
// Latency: an_n/seg_out are registered one cycle behind idx; a load shows from the frame after the next boundary.
// Backpressure: load_ready drops while a value is pending and rises the cycle after the frame boundary takes it.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [3:0]              dec_num,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_full;
    logic                    tick;
    logic                    boundary;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   an_onehot_n;

    assign tick        = (cnt == CW'(TICK_DIV - 1));
    assign boundary    = tick && (idx == IW'(NUM_DIGITS - 1));
    assign load_ready  = !pending_full;
    assign accept      = load_valid && load_ready;
    assign dec_num     = active[{idx, 2'b00} +: 4];
    assign an_onehot_n = ~(NUM_DIGITS'(1) << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Active only swaps at a frame boundary so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            if (boundary && pending_full) begin
                active       <= pending;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_run;

    // Walk down from the top digit; a digit is blank while everything above and including it is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (active[4*i +: 4] == 4'h0);
            blank[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            seg_out    <= 7'b0000000;
            frame_done <= 1'b0;
        end else begin
            an_n       <= blank[idx] ? '1 : an_onehot_n;
            seg_out    <= blank[idx] ? 7'b0000000 : dec_seg;
            frame_done <= boundary;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            seg_out    <= 7'b0000000;
            frame_done <= 1'b0;
        end else begin
            an_n       <= an_onehot_n;
            seg_out    <= dec_seg;
            frame_done <= boundary;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: arithmetic reference model plus directed and randomized loads.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int FR = N * TD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   load_data = 16'h0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [3:0]    dec_num;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_out;
    logic [3:0]    an_n;
    logic          frame_done;

    always #5 clk = ~clk;

    function automatic logic [6:0] deco(input logic [3:0] v);
        case (v)
            4'h0: deco = 7'b1111110;
            4'h1: deco = 7'b0110000;
            4'h2: deco = 7'b1101101;
            4'h3: deco = 7'b1111001;
            4'h4: deco = 7'b0110011;
            4'h5: deco = 7'b1011011;
            4'h6: deco = 7'b1011111;
            4'h7: deco = 7'b1110000;
            4'h8: deco = 7'b1111111;
            4'h9: deco = 7'b1111011;
            default: deco = 7'b0000001;
        endcase
    endfunction

    assign dec_seg = deco(dec_num);

    seg_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dec_num    (dec_num),
        .dec_seg    (dec_seg),
        .seg_out    (seg_out),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: mk counts clock edges since reset release; digit slot and frame position follow arithmetically.
    int          mk = 0;
    logic [15:0] m_act = 16'h0;
    logic [15:0] m_pend = 16'h0;
    bit          m_pf = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h0;
    bit          e_fd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int         d;
        logic [3:0] nib;
        bit         acc;
        bit         bnd;
        bit         blk;
        if (!rst_n) begin
            mk     = 0;
            m_act  = 16'h0;
            m_pend = 16'h0;
            m_pf   = 1'b0;
            e_an   = 4'hF;
            e_seg  = 7'h0;
            e_fd   = 1'b0;
        end else begin
            d   = (mk / TD) % N;
            nib = 4'(m_act >> (4 * d));
            bnd = (mk % FR) == FR - 1;
            acc = load_valid && !m_pf;
            blk = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            blk = (d > 0) && ((m_act >> (4 * d)) == 16'h0);
`endif
            e_an  = blk ? 4'hF : ~(4'b0001 << d);
            e_seg = blk ? 7'h0 : deco(nib);
            e_fd  = bnd;
            if (bnd && m_pf) begin
                m_act = m_pend;
                m_pf  = 1'b0;
            end
            if (acc) begin
                m_pend = load_data;
                m_pf   = 1'b1;
            end
            mk++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("an_n", 32'(an_n), 32'(e_an));
            chk("seg_out", 32'(seg_out), 32'(e_seg));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("load_ready", 32'(load_ready), 32'(!m_pf));
            chk("dec_num", 32'(dec_num), 32'(4'(m_act >> (4 * ((mk / TD) % N)))));
        end
    end

    task automatic goto_edge(input int t);
        int n;
        n = 0;
        while (mk < t && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("goto_edge", 32'(mk), 32'(t));
    endtask

    logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0F0F};

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_an_n", 32'(an_n), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        #2 rst_n = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1234;

        goto_edge(1);
        load_valid = 1'b0;
        chk("an_first", 32'(an_n), 32'hE);
        chk("ready_after_load", 32'(load_ready), 32'h0);
        goto_edge(4);  chk("an_slot0_end", 32'(an_n), 32'hE);
        goto_edge(5);  chk("an_slot1", 32'(an_n), 32'hD);
        goto_edge(9);  chk("an_slot2", 32'(an_n), 32'hB);
        goto_edge(13); chk("an_slot3", 32'(an_n), 32'h7);
        goto_edge(16);
        chk("fd_first", 32'(frame_done), 32'h1);
        chk("ready_rise", 32'(load_ready), 32'h1);
        goto_edge(17);
        chk("fd_pulse_end", 32'(frame_done), 32'h0);
        chk("seg_1234_d0", 32'(seg_out), 32'h33);
        goto_edge(29); chk("seg_1234_d3", 32'(seg_out), 32'h30);

        goto_edge(30);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        goto_edge(31);
        load_data = 16'h9999;
        chk("stall_second", 32'(load_ready), 32'h0);
        goto_edge(33);
        load_valid = 1'b0;
        chk("seg_5678_d0", 32'(seg_out), 32'h7F);
        chk("pending_9999", 32'(load_ready), 32'h0);
        goto_edge(49);
        chk("seg_9999_d0", 32'(seg_out), 32'h7B);
        load_valid = 1'b1;
        load_data  = 16'h00A0;
        goto_edge(50);
        load_valid = 1'b0;
        goto_edge(65);
        chk("seg_00a0_d0", 32'(seg_out), 32'h7E);
        chk("an_00a0_d0", 32'(an_n), 32'hE);
        goto_edge(69);
        chk("seg_00a0_d1", 32'(seg_out), 32'h01);
        goto_edge(73);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        chk("seg_00a0_d2", 32'(seg_out), 32'h00);
        chk("an_00a0_d2", 32'(an_n), 32'hF);
`else
        chk("seg_00a0_d2", 32'(seg_out), 32'h7E);
        chk("an_00a0_d2", 32'(an_n), 32'hB);
`endif

        goto_edge(79);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        goto_edge(80);
        load_valid = 1'b0;
        chk("fd_at_80", 32'(frame_done), 32'h1);
        chk("accept_on_boundary", 32'(load_ready), 32'h0);
        goto_edge(96); chk("fd_at_96", 32'(frame_done), 32'h1);
        goto_edge(97); chk("seg_4321_d0", 32'(seg_out), 32'h30);

        goto_edge(100);
        load_valid = 1'b1;
        load_data  = 16'h8888;
        goto_edge(102);
        load_valid = 1'b0;
        chk("pending_before_rst", 32'(load_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_an_n", 32'(an_n), 32'hF);
        chk("midrst_seg", 32'(seg_out), 32'h0);
        chk("midrst_ready", 32'(load_ready), 32'h1);
        chk("midrst_fd", 32'(frame_done), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        goto_edge(1);
        chk("post_rst_an", 32'(an_n), 32'hE);
        chk("post_rst_seg", 32'(seg_out), 32'h7E);
        chk("post_rst_ready", 32'(load_ready), 32'h1);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom) & masks[$urandom_range(0, 3)];
            if (i == 400) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        load_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
